// File: rtl/dac_frame_fmt.sv
// dac_frame_fmt: turns 32-bit I/Q samples into the interleaved 16-bit DAC word stream
// with a SYNC start-up burst, periodic FRAME markers, per-word parity and underflow zero-fill.
module dac_frame_fmt #(
  parameter int unsigned FRAME_PERIOD = 16,
  parameter int unsigned SYNC_LEN     = 32,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_iq_data,
  input  logic        i_iq_valid,
  output logic        o_iq_ready,
  output logic [15:0] o_dac_d,
  output logic        o_dac_frame,
  output logic        o_dac_parity,
  output logic        o_dac_sync,
  output logic [15:0] o_underflow_cnt
);

  localparam int unsigned W_WORD   = 16;
  localparam int unsigned W_SAMPLE = 32;
  localparam int unsigned W_CNT    = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [W_CNT-1:0]  SYNC_LAST  = W_CNT'(SYNC_LEN - 1);
  localparam logic [W_CNT-1:0]  FRAME_LAST = W_CNT'(FRAME_PERIOD - 1);
  localparam logic              PAR_INIT   = 1'(PARITY_ODD);
  localparam logic [W_WORD-1:0] UF_MAX     = '1;

  logic [1:0]          state_q, state_d;
  logic [W_CNT-1:0]    sync_cnt_q, sync_cnt_d;
  logic                phase_q, phase_d;
  logic [W_CNT-1:0]    smp_cnt_q, smp_cnt_d;
  logic [W_SAMPLE-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [W_WORD-1:0]   q_reg_q, q_reg_d;
  logic [W_WORD-1:0]   dac_d_q, dac_d_d;
  logic                dac_frame_q, dac_frame_d;
  logic                dac_parity_q, dac_parity_d;
  logic                dac_sync_q, dac_sync_d;
  logic [W_WORD-1:0]   uf_cnt_q, uf_cnt_d;
  logic                iq_ready_c;
  logic                accept_c;
  logic                consume_c;

  // Ready depends only on registered state; a phase-0 slot frees the hold on the same edge.
  assign iq_ready_c = ((state_q == ST_RUN) || (state_q == ST_SYNC)) &&
                      (!hold_valid_q || ((state_q == ST_RUN) && !phase_q));
  assign accept_c   = i_iq_valid && iq_ready_c;

  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    phase_d      = phase_q;
    smp_cnt_d    = smp_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    q_reg_d      = q_reg_q;
    dac_d_d      = dac_d_q;
    dac_frame_d  = dac_frame_q;
    dac_sync_d   = 1'b0;
    uf_cnt_d     = uf_cnt_q;
    consume_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dac_d_d      = '0;
        dac_frame_d  = 1'b0;
        q_reg_d      = '0;
        hold_valid_d = 1'b0;
        sync_cnt_d   = '0;
        if (i_enable) begin
          state_d    = ST_SYNC;
          dac_sync_d = 1'b1;
        end
      end

      ST_SYNC: begin
        dac_d_d     = '0;
        dac_frame_d = 1'b0;
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (sync_cnt_q == SYNC_LAST) begin
          state_d    = ST_RUN;
          phase_d    = 1'b0;
          smp_cnt_d  = '0;
          sync_cnt_d = '0;
        end else begin
          dac_sync_d = 1'b1;
          sync_cnt_d = sync_cnt_q + W_CNT'(1);
        end
      end

      ST_RUN: begin
        phase_d = !phase_q;
        if (!phase_q) begin
          // Sample slot advances even on underflow so the frame cadence never slips.
          dac_frame_d = (smp_cnt_q == '0);
          smp_cnt_d   = (smp_cnt_q == FRAME_LAST) ? '0 : smp_cnt_q + W_CNT'(1);
          if (hold_valid_q) begin
            dac_d_d   = hold_q[W_SAMPLE-1:W_WORD];
            q_reg_d   = hold_q[W_WORD-1:0];
            consume_c = 1'b1;
          end else begin
            dac_d_d = '0;
            q_reg_d = '0;
            if (uf_cnt_q != UF_MAX) begin
              uf_cnt_d = uf_cnt_q + W_WORD'(1);
            end
          end
        end else begin
          dac_d_d = q_reg_q;
          if (!i_enable) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_c) begin
      hold_d       = i_iq_data;
      hold_valid_d = 1'b1;
    end else if (consume_c) begin
      hold_valid_d = 1'b0;
    end

    dac_parity_d = (^dac_d_d) ^ PAR_INIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync_cnt_q   <= '0;
      phase_q      <= 1'b0;
      smp_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      q_reg_q      <= '0;
      dac_d_q      <= '0;
      dac_frame_q  <= 1'b0;
      dac_parity_q <= PAR_INIT;
      dac_sync_q   <= 1'b0;
      uf_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      phase_q      <= phase_d;
      smp_cnt_q    <= smp_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      q_reg_q      <= q_reg_d;
      dac_d_q      <= dac_d_d;
      dac_frame_q  <= dac_frame_d;
      dac_parity_q <= dac_parity_d;
      dac_sync_q   <= dac_sync_d;
      uf_cnt_q     <= uf_cnt_d;
    end
  end

  assign o_iq_ready      = iq_ready_c;
  assign o_dac_d         = dac_d_q;
  assign o_dac_frame     = dac_frame_q;
  assign o_dac_parity    = dac_parity_q;
  assign o_dac_sync      = dac_sync_q;
  assign o_underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_dac_frame_fmt.sv
// tb_dac_frame_fmt: scoreboard bench for dac_frame_fmt; an even- and an odd-parity
// instance share one stimulus stream and are checked every cycle against a spec-level model.
`timescale 1ns/1ps
module tb_dac_frame_fmt;

  localparam int unsigned FP = 16;
  localparam int unsigned SL = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;

  logic        rdy_e, rdy_o, fr_e, fr_o, par_e, par_o, sy_e, sy_o;
  logic [15:0] d_e, d_o, uf_e, uf_o;

  dac_frame_fmt #(.FRAME_PERIOD(FP), .SYNC_LEN(SL), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_iq_data(data), .i_iq_valid(valid),
    .o_iq_ready(rdy_e), .o_dac_d(d_e), .o_dac_frame(fr_e), .o_dac_parity(par_e),
    .o_dac_sync(sy_e), .o_underflow_cnt(uf_e));

  dac_frame_fmt #(.FRAME_PERIOD(FP), .SYNC_LEN(SL), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .i_enable(en), .i_iq_data(data), .i_iq_valid(valid),
    .o_iq_ready(rdy_o), .o_dac_d(d_o), .o_dac_frame(fr_o), .o_dac_parity(par_o),
    .o_dac_sync(sy_o), .o_underflow_cnt(uf_o));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected-behaviour model: queue holds accepted samples tagged with their accept edge.
  typedef struct { logic [31:0] smp; int cyc; } acc_t;
  typedef enum int { M_IDLE, M_SYNC, M_RUN_I, M_RUN_Q } mst_t;

  acc_t        q[$];
  mst_t        ms = M_IDLE;
  int          cyc = 0;
  int          sync_hi = 0;
  int          slot = 0;
  int          n_out = 0;
  int          obs_sync = 0;
  logic        prev_sy = 1'b0;
  logic [15:0] exp_d = '0, exp_q = '0, exp_uf = '0;
  logic        exp_fr = 1'b0, exp_sy = 1'b0, exp_rdy = 1'b0;
  logic [15:0] n_smp = '0;

  task automatic model_edge(input logic en_s);
    acc_t a;
    case (ms)
      M_IDLE: begin
        q.delete();
        exp_d = '0; exp_fr = 1'b0;
        if (en_s) begin ms = M_SYNC; exp_sy = 1'b1; sync_hi = 1; end
        else exp_sy = 1'b0;
      end
      M_SYNC: begin
        exp_d = '0; exp_fr = 1'b0;
        if (!en_s) begin ms = M_IDLE; exp_sy = 1'b0; q.delete(); end
        else if (sync_hi == SL) begin ms = M_RUN_I; exp_sy = 1'b0; slot = 0; end
        else begin exp_sy = 1'b1; sync_hi++; end
      end
      M_RUN_I: begin
        exp_fr = (slot == 0);
        slot = (slot == FP - 1) ? 0 : slot + 1;
        if (q.size() > 0 && q[0].cyc < cyc) begin
          a = q.pop_front();
          exp_d = a.smp[31:16];
          exp_q = a.smp[15:0];
          n_out++;
        end else begin
          exp_d = '0; exp_q = '0;
          if (exp_uf != 16'hFFFF) exp_uf = exp_uf + 16'd1;
        end
        ms = M_RUN_Q;
      end
      M_RUN_Q: begin
        exp_d = exp_q;
        if (!en_s) begin ms = M_IDLE; q.delete(); end
        else ms = M_RUN_I;
      end
      default: ms = M_IDLE;
    endcase
    exp_rdy = (ms != M_IDLE) && (q.size() == 0 || ms == M_RUN_I);
  endtask

  task automatic compare();
    check_eq("dac_d", d_e, exp_d);
    check_eq("dac_d_odd", d_o, exp_d);
    check_eq("dac_frame", fr_e, exp_fr);
    check_eq("dac_sync", sy_e, exp_sy);
    check_eq("parity_even", par_e, ^exp_d);
    check_eq("parity_odd", par_o, ~^exp_d);
    check_eq("underflow_cnt", uf_e, exp_uf);
    check_eq("iq_ready", rdy_e, exp_rdy);
    check_eq("iq_ready_odd", rdy_o, exp_rdy);
    if (exp_d == 16'h0001) check_eq("parity_even_0001", par_e, 1);
    if (exp_d == 16'h0003) check_eq("parity_odd_0003", par_o, 1);
    if (prev_sy && !sy_e && ms == M_RUN_I) check_eq("sync_len", obs_sync, SL);
    obs_sync = sy_e ? obs_sync + 1 : 0;
    prev_sy  = sy_e;
  endtask

  // One clock: capture acceptance before the edge, advance the model, check after it.
  task automatic step();
    logic        acc;
    logic        en_s;
    logic [31:0] smp;
    acc  = valid && rdy_e;
    en_s = en;
    smp  = data;
    @(posedge clk);
    cyc++;
    if (acc) begin
      q.push_back('{smp: smp, cyc: cyc});
      n_smp = n_smp + 16'd1;
    end
    model_edge(en_s);
    @(negedge clk);
    data = {n_smp, 16'h8000 | n_smp};
    compare();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_d"}, d_e, 0);
    check_eq({tag, "_frame"}, fr_e, 0);
    check_eq({tag, "_sync"}, sy_e, 0);
    check_eq({tag, "_parity_even"}, par_e, 0);
    check_eq({tag, "_parity_odd"}, par_o, 1);
    check_eq({tag, "_uf"}, uf_e, 0);
    check_eq({tag, "_ready"}, rdy_e, 0);
    check_eq({tag, "_d_odd"}, d_o, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi;
    int          zeros;
    logic [15:0] uf0;

    #1 rst = 1'b1;
    #1 check_reset("rst_init");
    @(negedge clk);
    rst  = 1'b0;
    data = {n_smp, 16'h8000 | n_smp};
    repeat (3) step();

    // SYNC then continuous ramp
    en = 1'b1; valid = 1'b1;
    while (n_out < 100 && cyc < 5000) step();
    check_eq("ramp_words", n_out, 100);
    check_eq("ramp_no_underflow", uf_e, 0);
    hi = 0;
    repeat (64) begin step(); hi += int'(rdy_e); end
    check_eq("ready_duty", hi, 32);

    // three dropped sample slots, aligned to a phase-0 edge
    while (ms != M_RUN_I && cyc < 6000) step();
    uf0 = uf_e; zeros = 0; valid = 1'b0;
    repeat (6) begin step(); zeros += int'(d_e == 0); end
    valid = 1'b1;
    repeat (40) begin step(); zeros += int'(d_e == 0); end
    check_eq("underflow_delta", 32'(uf_e - uf0), 3);
    check_eq("underflow_zero_words", zeros, 6);

    // disable on a phase-0 cycle: Q still goes out, then idle
    while (ms != M_RUN_I && cyc < 7000) step();
    en = 1'b0;
    step();
    step();
    check_eq("disable_q_word", d_e, exp_q);
    step();
    check_eq("disable_idle_d", d_e, 0);
    check_eq("disable_idle_frame", fr_e, 0);
    repeat (3) step();
    en = 1'b1;
    hi = n_out;
    while (n_out < hi + 20 && cyc < 8000) step();
    check_eq("resync_words", n_out, hi + 20);

    // asynchronous reset mid-RUN, no clock edge before checking
    while (ms != M_RUN_Q && cyc < 9000) step();
    #2 rst = 1'b1;
    #1 check_reset("rst_mid_run");
    en = 1'b0; valid = 1'b0;
    ms = M_IDLE; q.delete();
    exp_d = '0; exp_q = '0; exp_uf = '0; exp_fr = 1'b0; exp_sy = 1'b0; exp_rdy = 1'b0;
    @(negedge clk);
    compare();
    rst = 1'b0;
    step();

    // saturate the underflow counter with a long starved stream
    en = 1'b1;
    repeat (2 * (65540 + SL + 2)) step();
    check_eq("underflow_saturated", uf_e, 16'hFFFF);
    check_eq("underflow_saturated_odd", uf_o, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
